// File: rtl/izhikevich_neuron_core.sv
// izhikevich_neuron_core
// Clocked state-update engine for a single Izhikevich neuron. Holds v and u,
// accepts one input current per step handshake, evaluates the v and u updates
// over three multiply cycles on one shared signed multiplier, applies the spike
// reset and presents the result on a valid/ready output.
// Number format: signed Q8.8 (1 LSB = 1/256 mV); internal arithmetic 32-bit.
//
// Optional feature macro: SPIKE_COUNT_EN (saturating spike counter on
// spike_count; when undefined spike_count is tied to 0).
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   step_valid   step request valid
//   step_ready   core idle, a step can be accepted
//   i_in         signed Q8.8 input current for the step
//   out_valid    step result valid
//   out_ready    downstream accepts the result
//   v_out        signed Q8.8 membrane potential after the step
//   u_out        signed Q8.8 recovery variable after the step
//   spike        the step fired
//   spike_count  spikes since reset (SPIKE_COUNT_EN only)
module izhikevich_neuron_core #(
  parameter int A_Q      = 5,
  parameter int B_Q      = 51,
  parameter int C_Q      = -16640,
  parameter int D_Q      = 2048,
  parameter int V_PEAK   = 7680,
  parameter int DT_SHIFT = 1,
  parameter int U_INIT   = -3328
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_valid,
  output logic               step_ready,
  input  logic signed [15:0] i_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] v_out,
  output logic signed [15:0] u_out,
  output logic               spike,
  output logic [15:0]        spike_count
);

  typedef enum logic [2:0] {IDLE, MUL_VV, MUL_BV, MUL_AU, WRITE, OUT} state_t;

  state_t             state;
  logic signed [15:0] v;
  logic signed [15:0] u;
  logic signed [15:0] i_lat;

  logic signed [31:0] k_p0;
  logic signed [16:0] bv_p1;
  logic signed [31:0] v_new_p1;
  logic signed [31:0] u_new_p2;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7FFF;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  // One shared 17x16 signed multiplier; the operand pair is chosen by state.
  logic signed [16:0] mul_a;
  logic signed [15:0] mul_b;
  logic signed [32:0] prod;
  logic signed [16:0] bv_minus_u;

  assign bv_minus_u = bv_p1 - 17'(u);

  always_comb begin
    mul_a = 17'(v);
    mul_b = v;
    case (state)
      MUL_BV: begin
        mul_a = 17'(B_Q);
        mul_b = v;
      end
      MUL_AU: begin
        mul_a = bv_minus_u;
        mul_b = 16'(A_Q);
      end
      default: begin
        mul_a = 17'(v);
        mul_b = v;
      end
    endcase
    prod = mul_a * mul_b;
  end

  logic signed [31:0] v32;
  logic signed [31:0] u32;
  logic signed [31:0] vv;
  logic signed [31:0] k_c;
  logic signed [31:0] dv;
  logic signed [31:0] du;
  logic               fire;

  assign v32  = 32'(v);
  assign u32  = 32'(u);
  assign vv   = 32'(prod >>> 8);
  assign k_c  = (vv * 32'sd41) >>> 10;
  assign dv   = k_p0 + 32'sd5 * v32 + 32'sd35840 - u32 + 32'(i_lat);
  assign du   = 32'(prod >>> 8);
  // Threshold is tested on the unsaturated 32-bit value.
  assign fire = (v_new_p1 >= 32'(V_PEAK));

  // Datapath intermediates: only meaningful inside a step, never reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:   if (step_valid) i_lat <= i_in;
      // stage p0: quadratic term
      MUL_VV: k_p0 <= k_c;
      // stage p1: b*v and the v update
      MUL_BV: begin
        bv_p1    <= 17'(prod >>> 8);
        v_new_p1 <= v32 + (dv >>> DT_SHIFT);
      end
      // stage p2: u update from the pre-step v
      MUL_AU: u_new_p2 <= u32 + (du >>> DT_SHIFT);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      v          <= 16'(C_Q);
      u          <= 16'(U_INIT);
      v_out      <= 16'(C_Q);
      u_out      <= 16'(U_INIT);
      spike      <= 1'b0;
      out_valid  <= 1'b0;
      step_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (step_valid) begin
            state      <= MUL_VV;
            step_ready <= 1'b0;
          end
        end
        MUL_VV: state <= MUL_BV;
        MUL_BV: state <= MUL_AU;
        MUL_AU: state <= WRITE;
        WRITE: begin
          if (fire) begin
            v     <= 16'(C_Q);
            u     <= sat16(u_new_p2 + 32'(D_Q));
            v_out <= 16'(C_Q);
            u_out <= sat16(u_new_p2 + 32'(D_Q));
          end else begin
            v     <= sat16(v_new_p1);
            u     <= sat16(u_new_p2);
            v_out <= sat16(v_new_p1);
            u_out <= sat16(u_new_p2);
          end
          spike     <= fire;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            step_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          step_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] spike_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      spike_cnt <= 16'd0;
    else if (state == WRITE && fire && spike_cnt != 16'hFFFF)
      spike_cnt <= spike_cnt + 16'd1;
  end

  assign spike_count = spike_cnt;
`else
  assign spike_count = 16'd0;
`endif

endmodule

// File: tb/tb_izhikevich_neuron_core.sv
// Testbench for izhikevich_neuron_core: directed steps checked against a
// behavioural model of the neuron equations plus hand-computed literals.
module tb_izhikevich_neuron_core;

  localparam int A_Q      = 5;
  localparam int B_Q      = 51;
  localparam int C_Q      = -16640;
  localparam int D_Q      = 2048;
  localparam int V_PEAK   = 7680;
  localparam int DT_SHIFT = 1;
  localparam int U_INIT   = -3328;

  logic               clk = 1'b0;
  logic               rst;
  logic               step_valid;
  logic               step_ready;
  logic signed [15:0] i_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] v_out;
  logic signed [15:0] u_out;
  logic               spike;
  logic [15:0]        spike_count;

  izhikevich_neuron_core dut (
    .clk        (clk),
    .rst        (rst),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .i_in       (i_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .v_out      (v_out),
    .u_out      (u_out),
    .spike      (spike),
    .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state and the expectation for the step in flight.
  int m_v, m_u, m_cnt;
  int exp_v, exp_u, exp_spike, exp_cnt;
  bit armed = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint x, input longint d);
    longint q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  task automatic model_reset();
    m_v = C_Q;
    m_u = U_INIT;
    m_cnt = 0;
  endtask

  // dv = 0.04v^2 + 5v + 140 - u + I  (Q8.8, 0.04 ~ 41/1024), Euler step dt.
  task automatic model_step(input int i);
    longint v, u, vv, k, bv, dv, vn, du, un, dt;
    v  = m_v;
    u  = m_u;
    dt = longint'(1) << DT_SHIFT;
    vv = fdiv(v * v, 256);
    k  = fdiv(41 * vv, 1024);
    bv = fdiv(B_Q * v, 256);
    dv = k + 5 * v + 35840 - u + i;
    vn = v + fdiv(dv, dt);
    du = fdiv(A_Q * (bv - u), 256);
    un = u + fdiv(du, dt);
    if (vn >= V_PEAK) begin
      m_v = C_Q;
      m_u = clamp16(un + D_Q);
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      exp_spike = 1;
    end else begin
      m_v = clamp16(vn);
      m_u = clamp16(un);
      exp_spike = 0;
    end
    exp_v = m_v;
    exp_u = m_u;
`ifdef SPIKE_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
  endtask

  // Every cycle a result is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!armed) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("v_out", v_out, exp_v);
        check("u_out", u_out, exp_u);
        check("spike", spike, exp_spike);
        check("spike_count", spike_count, exp_cnt);
        check("step_ready_busy", step_ready, 0);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_v_out"}, v_out, C_Q);
    check({tag, "_u_out"}, u_out, U_INIT);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_step_ready"}, step_ready, 1);
    check({tag, "_spike"}, spike, 0);
    check({tag, "_spike_count"}, spike_count, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    armed = 1'b0;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_step(input int i, input int hold);
    check("ready_before_step", step_ready, 1);
    @(negedge clk);
    step_valid = 1'b1;
    i_in = 16'(i);
    out_ready = (hold == 0);
    @(posedge clk);
    model_step(i);
    armed = 1'b1;
    #1;
    step_valid = 1'b0;
    i_in = 16'sh1234;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1 check("latency_out_valid", out_valid, (n == 4) ? 1 : 0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      step_valid = 1'b1;
      i_in = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold_step_ready", step_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    @(negedge clk);
    step_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    armed = 1'b0;
    check("after_hs_out_valid", out_valid, 0);
    check("after_hs_step_ready", step_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    step_valid = 1'b0;
    out_ready = 1'b1;
    i_in = '0;
    model_reset();
    exp_v = C_Q; exp_u = U_INIT; exp_spike = 0; exp_cnt = 0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst = 1'b0;

    async_reset();

    // Single step from reset, no input current.
    do_step(0, 0);
    check("lit_step0_v", v_out, -17003);
    check("lit_step0_u", u_out, -3328);
    check("lit_step0_spike", spike, 0);

    // Two strong steps: second one fires.
    async_reset();
    do_step(32767, 0);
    check("lit_spk1_v", v_out, -620);
    check("lit_spk1_u", u_out, -3328);
    check("lit_spk1_spike", spike, 0);
    do_step(32767, 0);
    check("lit_spk2_v", v_out, -16640);
    check("lit_spk2_u", u_out, -1249);
    check("lit_spk2_spike", spike, 1);
`ifdef SPIKE_COUNT_EN
    check("lit_spk2_count", spike_count, 1);
`else
    check("lit_spk2_count", spike_count, 0);
`endif

    // Backpressure with ignored step requests while busy.
    do_step(1000, 10);
    do_step(-500, 0);

    // Reset while the core is in MUL_BV.
    @(negedge clk);
    step_valid = 1'b1;
    i_in = 16'sd32767;
    @(posedge clk);
    #1 step_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("midstep_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1 check("midstep_no_out_valid", out_valid, 0);
    end
    do_step(0, 0);
    check("lit_after_midrst_v", v_out, -17003);

    // Strong negative current saturates v at the bottom of the range.
    async_reset();
    do_step(-32768, 0);
    check("lit_vsat_v", v_out, -32768);
    check("lit_vsat_u", u_out, -3328);

    // Long run of strong steps: repeated spikes, u must follow the model.
    async_reset();
    for (int n = 0; n < 60; n++) begin
      do_step(32767, 0);
      check("run_u_model", u_out, m_u);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
